// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, quarter-phase constants and word-layout offsets for the I2C write master
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, START, BIT, ACK_S, STOP, DONE} state_t;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    // The whole word leaves MSB first, so the outgoing bit always sits at the top of the shift register
    localparam int WORD_MSB = 31;
    localparam logic [1:0] LAST_BYTE = 2'd3;
endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: quarter-SCL-period tick divider
// Ports: clk, rst_n (async active-low), clr (sync clear to 0), hold (freeze count), tick (one cycle per QDIV when not held)
module i2c_qtick_gen #(
    parameter int QDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int W = $clog2(QDIV);
    logic [W-1:0] cnt;
    assign tick = !hold && cnt == W'(QDIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!hold)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/i2c_write_master.sv
// i2c_write_master: serialises one 32-bit word (address, register, 16 data bits) as an I2C write
// Ports: iCLK, iRST_N (async active-low), I2C_DATA (word), GO (request level), END (done),
//        ACK (1 = NACK seen), I2C_SCLK (SCL push-pull), I2C_SDAT (SDA open-drain),
//        I2C_SCLK_IN (SCL readback, only with I2C_CLK_STRETCH_EN defined)
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [31:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
`ifdef I2C_CLK_STRETCH_EN
    input  logic        I2C_SCLK_IN,
`endif
    inout  wire         I2C_SDAT
);
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    if (QDIV < 2) begin : g_qdiv_check
        $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be >= 2");
    end
    state_t      state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] sh;
    logic        sda_low, scl_d, sda_low_d, tick, active, hold;
    assign active = state == START || state == BIT || state == ACK_S || state == STOP;
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N)
            scl_sync <= 2'b11;
        else
            scl_sync <= {scl_sync[0], I2C_SCLK_IN};
    // A slave stretching SCL keeps it low; wait in q1 until the line is seen high
    assign hold = active && q == Q1 && !scl_sync[1];
`else
    assign hold = 1'b0;
`endif
    i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
        .clk  (iCLK),
        .rst_n(iRST_N),
        .clr  (!active),
        .hold (hold),
        .tick (tick)
    );
    always_comb begin
        scl_d = 1'b1;
        sda_low_d = 1'b0;
        case (state)
            START: begin
                scl_d = q != Q3;
                sda_low_d = q == Q2 || q == Q3;
            end
            BIT: begin
                scl_d = q == Q1 || q == Q2;
                sda_low_d = !sh[WORD_MSB];
            end
            ACK_S: scl_d = q == Q1 || q == Q2;
            STOP: begin
                scl_d = q != Q0;
                sda_low_d = q == Q0 || q == Q1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            state <= IDLE;
            q <= Q0;
            bit_cnt <= '0;
            byte_cnt <= '0;
            sh <= '0;
            END <= 1'b0;
            ACK <= 1'b0;
            I2C_SCLK <= 1'b1;
            sda_low <= 1'b0;
        end else begin
            I2C_SCLK <= scl_d;
            sda_low <= sda_low_d;
            if (tick)
                q <= q + 1'b1;
            case (state)
                IDLE:
                    if (GO && !END) begin
                        sh <= I2C_DATA;
                        ACK <= 1'b0;
                        q <= Q0;
                        bit_cnt <= '0;
                        byte_cnt <= '0;
                        state <= START;
                    end
                START:
                    if (tick && q == Q3)
                        state <= BIT;
                BIT:
                    if (tick && q == Q3) begin
                        sh <= sh << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= ACK_S;
                    end
                ACK_S: begin
                    // Released SDA reading high at the end of q2 is a NACK
                    if (tick && q == Q2 && I2C_SDAT)
                        ACK <= 1'b1;
                    if (tick && q == Q3) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        state <= (ACK || byte_cnt == LAST_BYTE) ? STOP : BIT;
                    end
                end
                STOP:
                    if (tick && q == Q3)
                        state <= DONE;
                DONE:
                    if (!END)
                        END <= 1'b1;
                    else if (!GO) begin
                        END <= 1'b0;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: bus-level monitor and ACK/NACK slave model checking serialised bytes, timing and handshake
module tb_i2c_write_master;
    localparam int CLK_FREQ = 120000;
    localparam int I2C_FREQ = 10000;
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    logic clk = 0, rst_n = 0, go = 0, end_o, ack, scl, slave_low = 0;
    logic [31:0] data = 0;
    wire sda;
    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);
    int n_assert = 0, n_fail = 0, cyc = 0;
    logic [7:0] mon_bytes[$];
    logic [7:0] cur = 0;
    int scl_rises = 0, stops = 0, bitn = 0, nack_sel = 0;
    logic prev_scl = 1, prev_sda = 1;

    i2c_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
        .iCLK(clk), .iRST_N(rst_n), .I2C_DATA(data), .GO(go),
        .END(end_o), .ACK(ack), .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and slave: decode START/STOP/bits from the wires, ACK every byte except the chosen NACK byte
    always @(negedge clk) begin
        if (scl && prev_scl && prev_sda && !sda)
            bitn = 0;
        else if (scl && prev_scl && !prev_sda && sda)
            stops++;
        else if (scl && !prev_scl) begin
            scl_rises++;
            bitn++;
            if (bitn <= 8)
                cur = {cur[6:0], sda};
            if (bitn == 8)
                mon_bytes.push_back(cur);
            if (bitn == 9)
                bitn = 0;
        end else if (!scl && prev_scl)
            slave_low = (bitn == 8) && (nack_sel != mon_bytes.size());
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [31:0] word, input int nack, input bit pulse);
        int t0, n, slots, held;
        bit seen;
        n = (nack == 0) ? 4 : nack;
        slots = (nack == 0) ? 38 : 2 + 9 * nack;
        @(negedge clk);
        mon_bytes.delete();
        scl_rises = 0;
        stops = 0;
        nack_sel = nack;
        data = word;
        go = 1;
        @(posedge clk);
        #1 t0 = cyc;
        if (pulse) begin
            @(negedge clk);
            go = 0;
            data = $urandom;
        end
        seen = 0;
        for (int w = 0; w < 4000 && !seen; w++) begin
            @(negedge clk);
            seen = end_o;
        end
        check("end_seen", 32'(seen), 32'd1);
        check("end_latency", 32'(cyc - t0), 32'(slots * 4 * QDIV + 1));
        check("ack_flag", 32'(ack), 32'(nack != 0));
        check("byte_count", 32'(mon_bytes.size()), 32'(n));
        for (int i = 0; i < n && i < mon_bytes.size(); i++)
            check("byte", 32'(mon_bytes[i]), 32'(word[31-8*i -: 8]));
        check("scl_rises", 32'(scl_rises), 32'(9 * n + 1));
        check("stop_count", 32'(stops), 32'd1);
        if (pulse) begin
            @(negedge clk);
            check("end_one_cycle", 32'(end_o), 32'd0);
        end else begin
            held = 0;
            repeat (100) begin
                @(negedge clk);
                held += int'(end_o);
            end
            check("end_held", 32'(held), 32'd100);
            check("ack_stable", 32'(ack), 32'(nack != 0));
            go = 0;
            @(negedge clk);
            check("end_drop", 32'(end_o), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_end", 32'(end_o), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        rst_n = 1;
        run_txn(32'hBA090100, 0, 0);
        run_txn(32'hBA200000, 1, 1);
        for (int k = 0; k < 8; k++)
            run_txn($urandom, int'($urandom_range(4, 0)), k[0]);
        @(negedge clk);
        mon_bytes.delete();
        nack_sel = 0;
        data = $urandom;
        go = 1;
        @(negedge clk);
        go = 0;
        for (int w = 0; w < 4000 && mon_bytes.size() < 2; w++)
            @(negedge clk);
        repeat (12 * QDIV) @(negedge clk);
        check("mid_byte3", 32'(mon_bytes.size()), 32'd2);
        rst_n = 0;
        slave_low = 0;
        #1;
        check("mid_rst_scl", 32'(scl), 32'd1);
        check("mid_rst_sda", 32'(sda), 32'd1);
        check("mid_rst_end", 32'(end_o), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1;
        run_txn($urandom, 0, 1);
        run_txn($urandom, 3, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
